axi4_rd_burst_slave: RTL and testbench
======================================

AXI4_RD_BURST_SLAVE -- requirements
Module: axi4_rd_burst_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ID_W 4 transaction ID width.
  ADDR_W 32 AR byte-address width.
  DATA_W 32 beat width; power of two, >= 8.
  MEM_AW 10 memory word-address width.
REQ-002 Ports (name direction width meaning), clock and reset first:
  ACLK in 1 sole clock; all logic on rising edge.
  ARESET in 1 reset, asynchronous, active-high.
  ARID in ID_W read ID.
  ARADDR in ADDR_W start byte address.
  ARLEN in 8 beats minus one.
  ARBURST in 2 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
  ARVALID in 1 address valid.
  ARREADY out 1 address accept.
  RID out ID_W echoed ARID.
  RDATA out DATA_W read data.
  RRESP out 2 00 OKAY, 10 SLVERR.
  RLAST out 1 final beat.
  RVALID out 1 data valid.
  RREADY in 1 master data accept.
  MEM_EN out 1 synchronous memory read strobe.
  MEM_ADDR out MEM_AW memory word address.
  MEM_RDATA in DATA_W memory data, valid exactly one cycle after MEM_EN.

Function
REQ-003 The block SHALL implement states IDLE and BURST; ARREADY=1 only in IDLE.
REQ-004 On an ARVALID&ARREADY edge the block SHALL latch ARID, ARADDR, ARLEN and ARBURST and enter BURST.
REQ-005 Every beat is full-width; the word address SHALL be ARADDR[log2(DATA_W/8)+MEM_AW-1 : log2(DATA_W/8)], and the low byte-offset bits SHALL be ignored.
REQ-006 Address sequence:
  FIXED: same word on every beat.
  INCR: +1 word per beat, modulo 2^MEM_AW.
  WRAP: +1 word, wrapping inside an aligned window of ARLEN+1 words.
REQ-007 WRAP with ARLEN not in {1,3,7,15}, and reserved ARBURST, SHALL return ARLEN+1 beats with RRESP=10 and RDATA=0, with no MEM_EN.
REQ-008 Memory data SHALL land in a 2-entry output FIFO that drives the R channel.
REQ-009 MEM_EN SHALL pulse only when beats remain to be issued and FIFO occupancy plus in-flight reads, minus this cycle's pop, is below 2.
REQ-010 Latency: with AR handshake in cycle T, MEM_EN SHALL assert in T+1 and RVALID in T+2.
REQ-011 Throughput: with RREADY held at 1, the block SHALL deliver one beat per cycle with no bubbles.
REQ-012 RVALID SHALL remain asserted, and RDATA/RRESP/RLAST/RID SHALL remain stable, until RREADY=1.
REQ-013 RLAST SHALL be 1 only on beat ARLEN; RID SHALL equal the latched ARID on every beat.
REQ-014 After the RLAST handshake the block SHALL return to IDLE, and ARREADY SHALL rise in the next cycle.
REQ-015 A new AR is never accepted in the same cycle as the RLAST handshake.
REQ-016 ARLEN=0 SHALL produce a single beat with RLAST=1.

Reset
REQ-017 While ARESET=1 the block SHALL force state IDLE and an empty FIFO, with ARREADY=0, RVALID=0, RLAST=0, MEM_EN=0, and RID, RDATA, RRESP and MEM_ADDR all 0.
REQ-018 ARREADY SHALL be 1 in the first cycle after ARESET deasserts.
REQ-019 Reset mid-burst SHALL discard the remaining beats and in-flight memory data, with no R beat after reset.

Configuration
REQ-020 Macro AXI4_RD_WRAP_EN controls WRAP-burst support.
  Defined: WRAP bursts are served per REQ-006 and REQ-007.
  Undefined: every WRAP burst SHALL be answered as in REQ-007 (SLVERR, RDATA=0, no MEM_EN); FIXED and INCR are unchanged.

Verification
REQ-021 INCR, ARADDR=0x10, ARLEN=3, ARID=5, RREADY=1 -> MEM_ADDR 4,5,6,7; 4 beats in consecutive cycles from T+2; RID=5; RLAST on beat 3; RRESP=00.
REQ-022 WRAP, ARADDR=0x18, ARLEN=3, macro defined -> MEM_ADDR 6,7,4,5.
REQ-023 Same WRAP with macro undefined -> 4 beats, RRESP=10, RDATA=0, MEM_EN never asserted.
REQ-024 INCR, ARLEN=7, RREADY toggling 1,0,0,1 -> 8 beats in order, data stable while stalled, at most 2 MEM_EN issued ahead of pops.
REQ-025 FIXED, ARADDR=0x40, ARLEN=2 -> MEM_ADDR 16 three times, RLAST on the third beat.
REQ-026 ARESET pulse after beat 1 of an ARLEN=7 burst -> RVALID=0 in the cycle ARESET asserts, no further beats, ARREADY=1 in the first cycle after release.

Source files
------------

// File: rtl/axi4_rd_burst_slave.sv
// axi4_rd_burst_slave: AXI4 read-only burst slave in front of a synchronous
// single-cycle-latency memory. Supports FIXED, INCR and (optionally) WRAP.
// Optional feature macro: AXI4_RD_WRAP_EN (defined = WRAP bursts served,
// undefined = every WRAP burst answered with SLVERR and no memory access).
//
// Handshake rules (AR and R): a transfer happens on a rising ACLK edge where
// both VALID and READY are 1. Once RVALID is raised it stays high, and
// RID/RDATA/RRESP/RLAST hold their values, until the RREADY=1 edge.
//
// R-channel datapath: a read issued in cycle N returns on MEM_RDATA in
// cycle N+1 (the "pending" slot). The R channel shows the oldest of
// {FIFO entries, pending slot}, so a read can go out the same cycle its data
// arrives. Pending data that is not consumed at once drops into a 2-entry
// FIFO. Error beats use the same path, with zero data, and never strobe
// MEM_EN.
module axi4_rd_burst_slave #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic              MEM_EN,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              dbg_state
);

  localparam int OFF = $clog2(DATA_W / 8);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state;
  logic [ID_W-1:0]   id_q;
  logic [MEM_AW-1:0] addr_q;
  logic [MEM_AW-1:0] mask_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [8:0]        left_q;

  logic              pend_q;
  logic              pend_last_q;
  logic              pend_err_q;

  logic [DATA_W-1:0] f_data [2];
  logic              f_err  [2];
  logic              f_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count_q;

  logic              ar_err;
  logic [MEM_AW-1:0] next_addr;
  logic              pop;
  logic              fifo_pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;
  logic              h_err;
  logic [DATA_W-1:0] pend_data;
  logic              unused_addr;

  // Byte-offset and upper address bits beyond the memory are ignored.
  assign unused_addr = ^ARADDR;

  assign ARREADY   = (state == IDLE) && !ARESET;
  assign dbg_state = (state == BURST);
  assign RID       = id_q;
  assign MEM_ADDR  = addr_q;

`ifdef AXI4_RD_WRAP_EN
  logic wrap_ok;
  // WRAP is legal only for 2, 4, 8 or 16 beats; reserved burst type is an error.
  always_comb begin
    wrap_ok = (ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15);
    ar_err  = (ARBURST == 2'b11) || ((ARBURST == 2'b10) && !wrap_ok);
  end
`else
  // Without WRAP support both WRAP and the reserved encoding are errors.
  always_comb begin
    ar_err = ARBURST[1];
  end
`endif

  // Next word address for the burst type in progress.
  always_comb begin
    next_addr = addr_q;
    case (burst_q)
      2'b01:   next_addr = addr_q + MEM_AW'(1);
      2'b10:   next_addr = (addr_q & ~mask_q) | ((addr_q + MEM_AW'(1)) & mask_q);
      default: next_addr = addr_q;
    endcase
  end

  // Head of the R channel: oldest FIFO entry, else the data returning now.
  always_comb begin
    pend_data = pend_err_q ? '0 : MEM_RDATA;
    RVALID    = (count_q != 2'd0) || pend_q;
    RDATA     = '0;
    RLAST     = 1'b0;
    h_err     = 1'b0;
    if (count_q != 2'd0) begin
      RDATA = f_data[rd_ptr];
      RLAST = f_last[rd_ptr];
      h_err = f_err[rd_ptr];
    end else if (pend_q) begin
      RDATA = pend_data;
      RLAST = pend_last_q;
      h_err = pend_err_q;
    end
    RRESP = h_err ? 2'b10 : 2'b00;
  end

  // Issue a beat only if the FIFO will still have room when its data lands.
  always_comb begin
    pop      = RVALID && RREADY;
    fifo_pop = pop && (count_q != 2'd0);
    push     = pend_q && !((count_q == 2'd0) && pop);
    occ      = {1'b0, count_q} + {2'b00, pend_q};
    issue    = (state == BURST) && (left_q != 9'd0) && (occ < (3'd2 + {2'b00, pop}));
    MEM_EN   = issue && !err_q;
  end

  // Burst FSM: accept AR in IDLE, walk addresses in BURST, leave on RLAST.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      burst_q <= 2'b00;
      err_q   <= 1'b0;
      left_q  <= 9'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ARVALID) begin
            id_q    <= ARID;
            addr_q  <= ARADDR[OFF+MEM_AW-1:OFF];
            mask_q  <= MEM_AW'(ARLEN[3:0]);
            burst_q <= ARBURST;
            err_q   <= ar_err;
            left_q  <= {1'b0, ARLEN} + 9'd1;
            state   <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            left_q <= left_q - 9'd1;
            addr_q <= next_addr;
          end
          if (pop && RLAST) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending slot and 2-entry output FIFO.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_err_q  <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_err[i]  <= 1'b0;
        f_last[i] <= 1'b0;
      end
    end else begin
      pend_q      <= issue;
      pend_last_q <= issue && (left_q == 9'd1);
      pend_err_q  <= err_q;
      if (push) begin
        f_data[wr_ptr] <= pend_data;
        f_err[wr_ptr]  <= pend_err_q;
        f_last[wr_ptr] <= pend_last_q;
        wr_ptr         <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, fifo_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_rd_burst_slave.sv
// Testbench for axi4_rd_burst_slave: directed AR bursts, a registered memory
// model, and a negedge monitor that checks R beats and MEM_ADDR against
// expected queues filled when each burst is issued.
module tb_axi4_rd_burst_slave;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 10;
  localparam int BW     = ID_W + DATA_W + 3;

  logic              ACLK;
  logic              ARESET;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  logic              MEM_EN;
  logic [MEM_AW-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [BW-1:0]     exp_q[$];
  logic [MEM_AW-1:0] exp_addr_q[$];
  int                beat_cyc_q[$];
  int                memen_cyc_q[$];
  int                memen_cnt = 0;
  int                pop_cnt   = 0;
  int                max_ahead = 0;
  int                hs_cyc    = 0;
  bit                prev_stall = 0;
  bit                last_seen  = 0;
  logic [BW-1:0]     prev_beat;
  logic [BW-1:0]     cur_beat;
  bit                rr_mode = 0;
  logic [3:0]        rr_pat  = 4'b1001;
  int                rr_idx  = 0;

  axi4_rd_burst_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Memory content: word a holds 0x1000_0000 | a; data appears one cycle after MEM_EN.
  function automatic logic [DATA_W-1:0] mem_word(input logic [MEM_AW-1:0] a);
    return 32'h1000_0000 | 32'(a);
  endfunction

  always @(posedge ACLK) begin
    if (MEM_EN) MEM_RDATA <= mem_word(MEM_ADDR);
  end

  // RREADY driver: always 1, or the 1,0,0,1 pattern.
  initial begin
    RREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      RREADY = rr_mode ? rr_pat[rr_idx % 4] : 1'b1;
      rr_idx++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got event, want none (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge ACLK) begin
    cur_beat = {RID, RDATA, RRESP, RLAST};
    if (!ARESET) begin
      if (prev_stall) begin
        check("r_hold_valid", 64'(RVALID), 64'd1);
        check("r_hold_payload", 64'(cur_beat), 64'(prev_beat));
      end
      prev_stall = RVALID && !RREADY;
      prev_beat  = cur_beat;
      if (last_seen) check("arready_after_last", 64'(ARREADY), 64'd1);
      last_seen = 0;
      if (MEM_EN) begin
        memen_cnt++;
        memen_cyc_q.push_back(cyc);
        if (exp_addr_q.size() == 0) fail_now("mem_en_unexpected");
        else check("mem_addr", 64'(MEM_ADDR), 64'(exp_addr_q.pop_front()));
      end
      if (RVALID && RREADY) begin
        pop_cnt++;
        beat_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) fail_now("r_beat_unexpected");
        else check("r_beat", 64'(cur_beat), 64'(exp_q.pop_front()));
        if (RLAST) begin
          check("arready_during_last", 64'(ARREADY), 64'd0);
          last_seen = 1;
        end
      end
      if (memen_cnt - pop_cnt > max_ahead) max_ahead = memen_cnt - pop_cnt;
    end else begin
      prev_stall = 0;
      last_seen  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    beat_cyc_q.delete();
    memen_cyc_q.delete();
    memen_cnt = 0;
    pop_cnt   = 0;
    max_ahead = 0;
  endtask

  task automatic exp_ok(input logic [ID_W-1:0] id, input logic [MEM_AW-1:0] a, input bit last);
    exp_addr_q.push_back(a);
    exp_q.push_back({id, mem_word(a), 2'b00, last});
  endtask

  task automatic exp_err(input logic [ID_W-1:0] id, input bit last);
    exp_q.push_back({id, 32'h0, 2'b10, last});
  endtask

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    bit got;
    got = 0;
    @(posedge ACLK);
    #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (ARREADY) begin
        got    = 1;
        hs_cyc = cyc;
        break;
      end
    end
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
    if (!got) fail_now("ar_accept_timeout");
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge ACLK);
      if (exp_q.size() == 0 && exp_addr_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s: got %0d beats outstanding, want 0", name, exp_q.size());
      exp_q.delete();
      exp_addr_q.delete();
    end
    repeat (3) @(posedge ACLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ARESET = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0;
    #2;
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_rvalid",  64'(RVALID),  64'd0);
    check("rst_rlast",   64'(RLAST),   64'd0);
    check("rst_mem_en",  64'(MEM_EN),  64'd0);
    check("rst_rid",     64'(RID),     64'd0);
    check("rst_rdata",   64'(RDATA),   64'd0);
    check("rst_rresp",   64'(RRESP),   64'd0);
    check("rst_mem_addr", 64'(MEM_ADDR), 64'd0);
    repeat (3) @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    #1;
    check("arready_after_reset", 64'(ARREADY), 64'd1);

    // INCR 0x10 len3 id5: words 4..7, beats from T+2 back to back.
    clear_stats();
    exp_ok(4'd5, 10'd4, 0); exp_ok(4'd5, 10'd5, 0);
    exp_ok(4'd5, 10'd6, 0); exp_ok(4'd5, 10'd7, 1);
    send_ar(4'd5, 32'h10, 8'd3, 2'b01);
    wait_done("incr_basic");
    check("incr_beat_count", 64'(beat_cyc_q.size()), 64'd4);
    if (memen_cyc_q.size() > 0) check("incr_mem_en_lat", 64'(memen_cyc_q[0]), 64'(hs_cyc + 1));
    else fail_now("incr_no_mem_en");
    if (beat_cyc_q.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check("incr_beat_cycle", 64'(beat_cyc_q[i]), 64'(hs_cyc + 2 + i));
    end

    // WRAP 0x18 len3.
    clear_stats();
`ifdef AXI4_RD_WRAP_EN
    exp_ok(4'd3, 10'd6, 0); exp_ok(4'd3, 10'd7, 0);
    exp_ok(4'd3, 10'd4, 0); exp_ok(4'd3, 10'd5, 1);
    send_ar(4'd3, 32'h18, 8'd3, 2'b10);
    wait_done("wrap4");
    check("wrap4_mem_en_cnt", 64'(memen_cnt), 64'd4);
`else
    exp_err(4'd3, 0); exp_err(4'd3, 0); exp_err(4'd3, 0); exp_err(4'd3, 1);
    send_ar(4'd3, 32'h18, 8'd3, 2'b10);
    wait_done("wrap4_disabled");
    check("wrap4_disabled_mem_en_cnt", 64'(memen_cnt), 64'd0);
`endif

    // INCR len7 with RREADY 1,0,0,1: ordered, stable under stall, <=2 ahead.
    clear_stats();
    for (int i = 0; i < 8; i++) exp_ok(4'd9, 10'(64 + i), i == 7);
    rr_idx  = 0;
    rr_mode = 1;
    send_ar(4'd9, 32'h100, 8'd7, 2'b01);
    wait_done("incr8_stall");
    rr_mode = 0;
    check("incr8_beat_count", 64'(pop_cnt), 64'd8);
    check("incr8_max_ahead_le2", 64'(max_ahead <= 2), 64'd1);

    // FIXED 0x40 len2: word 16 three times.
    clear_stats();
    exp_ok(4'd2, 10'd16, 0); exp_ok(4'd2, 10'd16, 0); exp_ok(4'd2, 10'd16, 1);
    send_ar(4'd2, 32'h40, 8'd2, 2'b00);
    wait_done("fixed3");
    check("fixed3_beat_count", 64'(pop_cnt), 64'd3);

    // ARLEN=0: single beat with RLAST, byte offset ignored.
    clear_stats();
    exp_ok(4'd1, 10'd31, 1);
    send_ar(4'd1, 32'h7E, 8'd0, 2'b01);
    wait_done("single");
    check("single_beat_count", 64'(pop_cnt), 64'd1);

    // INCR across the top of memory wraps modulo 2^MEM_AW.
    clear_stats();
    exp_ok(4'd7, 10'd1023, 0); exp_ok(4'd7, 10'd0, 1);
    send_ar(4'd7, 32'hFFE, 8'd1, 2'b01);
    wait_done("incr_rollover");

    // WRAP with illegal length: SLVERR, zero data, no memory reads.
    clear_stats();
    exp_err(4'd6, 0); exp_err(4'd6, 0); exp_err(4'd6, 1);
    send_ar(4'd6, 32'h20, 8'd2, 2'b10);
    wait_done("wrap_bad_len");
    check("wrap_bad_len_mem_en_cnt", 64'(memen_cnt), 64'd0);

    // Reserved burst type.
    clear_stats();
    exp_err(4'hA, 0); exp_err(4'hA, 1);
    send_ar(4'hA, 32'h30, 8'd1, 2'b11);
    wait_done("reserved");
    check("reserved_mem_en_cnt", 64'(memen_cnt), 64'd0);

    // Reset after beat 1 of an 8-beat burst.
    clear_stats();
    for (int i = 0; i < 8; i++) exp_ok(4'd4, 10'(200 + i), i == 7);
    send_ar(4'd4, 32'h320, 8'd7, 2'b01);
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (pop_cnt >= 2) break;
    end
    check("reset_mid_pops_before", 64'(pop_cnt), 64'd2);
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    #1;
    check("reset_mid_rvalid", 64'(RVALID), 64'd0);
    check("reset_mid_mem_en", 64'(MEM_EN), 64'd0);
    check("reset_mid_arready", 64'(ARREADY), 64'd0);
    @(posedge ACLK);
    #2;
    ARESET = 1'b0;
    #1;
    check("reset_mid_arready_release", 64'(ARREADY), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      check("reset_mid_no_beat", 64'(RVALID), 64'd0);
    end

    // Block still works after the mid-burst reset.
    clear_stats();
    exp_ok(4'hC, 10'd8, 0); exp_ok(4'hC, 10'd9, 1);
    send_ar(4'hC, 32'h20, 8'd1, 2'b01);
    wait_done("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
